fraccion: RTL and testbench

// - Converts a 4-bit binary fraction b (value b/16, fractional part of a fixed-point number) to decimal.
// - Outputs the tenths digit d for the display path, plus the exact 4-digit BCD expansion.
// - Sits between the fixed-point datapath and the decimal-display driver (fractional-part digit).
// - Iterative multiply-by-10 engine, one digit per clock.

---
 rtl/fraccion_if.sv | 13 +
 rtl/fraccion.sv | 92 +++++++++
 tb/tb_fraccion.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fraccion_if.sv
// Handshake and result bus between the fixed-point datapath and the fraccion converter.
// The master drives the 4-bit fraction and collects the decimal result; the slave is the converter.
interface fraccion_if;
    logic        in_valid;
    logic [3:0]  b;
    logic        busy;
    logic        out_valid;
    logic [3:0]  d;
    logic [15:0] bcd;

    modport master (output in_valid, b, input busy, out_valid, d, bcd);
    modport slave  (input in_valid, b, output busy, out_valid, d, bcd);
endinterface

// File: rtl/fraccion.sv
// Iterative binary-fraction-to-decimal converter: one BCD digit per clock via multiply-by-10.
// Define FRACCION_ROUND_EN to round the tenths digit half-up instead of truncating it.
module fraccion (
    input  logic      clk,
    input  logic      rst,
    fraccion_if.slave bus
);
    typedef enum logic {IDLE, CONV} state_t;

    state_t      state, state_next;
    logic [3:0]  r;
    logic [1:0]  k;
    logic [11:0] digits;
    logic [7:0]  p;
    logic        accept, last;
    logic [3:0]  d_new;
    logic        out_valid_q;
    logic [3:0]  d_q;
    logic [15:0] bcd_q;

    // r*10 as (r<<3)+(r<<1); the high nibble is the next decimal digit.
    assign p = {1'b0, r, 3'b000} + {3'b000, r, 1'b0};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (k == 2'd3) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The second digit is already stored when the last digit emerges, so rounding needs no extra cycle.
`ifdef FRACCION_ROUND_EN
    assign d_new = digits[11:8] + ((digits[7:4] >= 4'd5) ? 4'd1 : 4'd0);
`else
    assign d_new = digits[11:8];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= 4'd0;
            k           <= 2'd0;
            digits      <= 12'd0;
            out_valid_q <= 1'b0;
            d_q         <= 4'd0;
            bcd_q       <= 16'd0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                r <= bus.b;
                k <= 2'd0;
            end else if (state == CONV) begin
                r <= p[3:0];
                k <= k + 2'd1;
                if (k == 2'd0) digits[11:8] <= p[7:4];
                if (k == 2'd1) digits[7:4]  <= p[7:4];
                if (k == 2'd2) digits[3:0]  <= p[7:4];
                if (last) begin
                    bcd_q       <= {digits, p[7:4]};
                    d_q         <= d_new;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state == CONV);
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bcd       = bcd_q;
endmodule

// File: tb/tb_fraccion.sv
// Directed self-checking bench for fraccion: reset, full sweep, latency, wrap, hold,
// continuous in_valid and mid-conversion reset.
module tb_fraccion;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    fraccion_if bus ();

    fraccion dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] bcd_tab [16] = '{16'h0000, 16'h0625, 16'h1250, 16'h1875,
                                  16'h2500, 16'h3125, 16'h3750, 16'h4375,
                                  16'h5000, 16'h5625, 16'h6250, 16'h6875,
                                  16'h7500, 16'h8125, 16'h8750, 16'h9375};
`ifdef FRACCION_ROUND_EN
    logic [3:0] d_tab [16] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4,
                               4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9};
`else
    logic [3:0] d_tab [16] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4,
                               4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9};
`endif

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    // Issues one conversion and checks latency, result and the single-cycle pulse.
    task automatic applyStimulus(input logic [7:0] src, input string tag);
        int idx;
        int lat;
        idx = int'(src[3:0]);
        waitIdle();
        bus.b        = src[3:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (lat = 1; lat <= 8; lat++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) break;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd), 32'(bcd_tab[idx]));
        checkOutput({tag, "_d"}, 32'(bus.d), 32'(d_tab[idx]));
        checkOutput({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] cont_vals [15] = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4,
                                       4'd9, 4'd1, 4'd2, 4'd3, 4'd4,
                                       4'd14, 4'd1, 4'd2, 4'd3, 4'd4};
        int pulses;
        int bad;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.b        = 4'd0;
        #12;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_d", 32'(bus.d), 32'd0);
        checkOutput("rst_bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), $sformatf("sweep%0d", i));
        end

        for (int i = 16; i < 20; i++) begin
            applyStimulus(8'(i), $sformatf("wrap%0d", i));
        end

        // Last result was source 19, i.e. b=3.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0 || bus.bcd !== bcd_tab[3] || bus.d !== d_tab[3]) bad++;
        end
        checkOutput("hold_glitches", 32'(bad), 32'd0);

        waitIdle();
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            bus.b        = cont_vals[c];
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) pulses++;
            if (c == 4 || c == 9 || c == 14) begin
                checkOutput($sformatf("cont%0d_ov", c), 32'(bus.out_valid), 32'd1);
                checkOutput($sformatf("cont%0d_bcd", c), 32'(bus.bcd), 32'(bcd_tab[cont_vals[c - 4]]));
                checkOutput($sformatf("cont%0d_d", c), 32'(bus.d), 32'(d_tab[cont_vals[c - 4]]));
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("cont_pulses", 32'(pulses), 32'd3);

        waitIdle();
        bus.b        = 4'd6;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_d", 32'(bus.d), 32'd0);
        checkOutput("abort_bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
        checkOutput("abort_bcd_held", 32'(bus.bcd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
